credit_tx: RTL and testbench

CREDIT_TX -- requirements
Module: credit_tx

---
 rtl/credit_tx_pkg.sv | 7 +
 rtl/credit_tx_fifo.sv | 64 ++++++
 rtl/credit_tx.sv | 89 ++++++++
 tb/tb_credit_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_tx_pkg.sv
// Shared configuration for the credit-based transmitter slice.
// Holds the default datapath width used by credit_tx and its FIFO.
package credit_tx_pkg;

  localparam int unsigned PATH_BITS = 8;

endpackage

// File: rtl/credit_tx_fifo.sv
// tx_fifo: power-of-two circular FIFO holding words awaiting credits.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push_valid   producer offers push_data
//   push_data    word to enqueue
//   push_ready   occupancy < DEPTH (registered state only)
//   pop          consumer removes the head word this cycle
//   head         word at the read pointer
//   not_empty    occupancy > 0
module tx_fifo #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  input  logic [BITS-1:0] push_data,
  output logic            push_ready,
  input  logic            pop,
  output logic [BITS-1:0] head,
  output logic            not_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   count;
  logic            push;
  logic            do_pop;

  // Readiness derives only from the occupancy register, so a pop in the
  // same cycle never opens a slot for a simultaneous push when full.
  assign push_ready = (count < OW'(DEPTH));
  assign not_empty  = (count != '0);
  assign push       = push_valid && push_ready;
  assign do_pop     = pop && not_empty;
  assign head       = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers/occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/credit_tx.sv
// credit_tx: credit-gated transmitter. Words are queued in tx_fifo and sent
// one per cycle while credits remain; downstream returns credits via
// credit_in pulses.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_valid    producer offers push_data
//   push_data     word offered by producer
//   push_ready    FIFO can accept a word this cycle
//   credit_in     one-cycle pulse returning one credit
//   valid_out     registered pulse marking a word on data_out
//   data_out      registered word sent downstream
//   credit_count  current credit counter
//   err_out       sticky: credit returned while counter saturated
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int unsigned BITS         = PATH_BITS,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned INIT_CREDITS = 1,
  parameter int unsigned CREDIT_MAX   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_valid,
  input  logic [BITS-1:0]                 push_data,
  output logic                            push_ready,
  input  logic                            credit_in,
  output logic                            valid_out,
  output logic [BITS-1:0]                 data_out,
  output logic [$clog2(CREDIT_MAX+1)-1:0] credit_count,
  output logic                            err_out
);

  localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

  logic            send;
  logic            fifo_has_data;
  logic [BITS-1:0] head;
  logic [CW-1:0]   credit_next;
  logic            err_set;

  // Send uses only registered occupancy and credits; a credit arriving this
  // cycle is usable from the next edge onward.
  assign send = fifo_has_data && (credit_count != '0);

  tx_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (send),
    .head       (head),
    .not_empty  (fifo_has_data)
  );

  // A returned credit and a send in the same cycle cancel, so saturation
  // (and the error flag) only matters when no send happens.
  always_comb begin
    credit_next = credit_count;
    err_set     = 1'b0;
    case ({credit_in, send})
      2'b10: begin
        if (credit_count == CW'(CREDIT_MAX)) err_set = 1'b1;
        else                                 credit_next = credit_count + 1'b1;
      end
      2'b01:   credit_next = credit_count - 1'b1;
      default: credit_next = credit_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out    <= 1'b0;
      data_out     <= '0;
      credit_count <= CW'(INIT_CREDITS);
      err_out      <= 1'b0;
    end else begin
      valid_out    <= send;
      if (send) data_out <= head;
      credit_count <= credit_next;
      if (err_set) err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_credit_tx.sv
// Directed self-checking bench for credit_tx with default parameters
// (BITS=8, DEPTH=4, INIT_CREDITS=1, CREDIT_MAX=4).
module tb_credit_tx;
  import credit_tx_pkg::*;

  localparam int unsigned BITS         = PATH_BITS;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned INIT_CREDITS = 1;
  localparam int unsigned CREDIT_MAX   = 4;
  localparam int unsigned CW           = $clog2(CREDIT_MAX + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            push_valid;
  logic [BITS-1:0] push_data;
  logic            push_ready;
  logic            credit_in;
  logic            valid_out;
  logic [BITS-1:0] data_out;
  logic [CW-1:0]   credit_count;
  logic            err_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  credit_tx #(
    .BITS         (BITS),
    .DEPTH        (DEPTH),
    .INIT_CREDITS (INIT_CREDITS),
    .CREDIT_MAX   (CREDIT_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .credit_in    (credit_in),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .credit_count (credit_count),
    .err_out      (err_out)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push_valid = 1'b0; push_data = '0; credit_in = 1'b0;
    step();
    n_cmp++;
    if ({push_ready, valid_out, data_out, credit_count, err_out} !== {1'b1, 1'b0, 8'h00, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h",
               {push_ready, valid_out, data_out, credit_count, err_out}, {1'b1, 1'b0, 8'h00, 3'd1, 1'b0});
    end
    rst = 1'b0;
  endtask

  // One word, one credit: sent one cycle after acceptance, credit consumed.
  task automatic test_single();
    push_valid = 1'b1; push_data = 8'hA5;
    step();
    push_valid = 1'b0; push_data = 8'h00;
    n_cmp++;
    if ({valid_out, credit_count, push_ready} !== {1'b0, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL single_no_bypass got %h want %h", {valid_out, credit_count, push_ready}, {1'b0, 3'd1, 1'b1});
    end
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'hA5, 3'd0}) begin
      n_bad++;
      $display("FAIL single_send got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'hA5, 3'd0});
    end
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b0, 8'hA5, 3'd0}) begin
      n_bad++;
      $display("FAIL single_hold got %h want %h", {valid_out, data_out, credit_count}, {1'b0, 8'hA5, 3'd0});
    end
  endtask

  // No credits: words queue; one credit pulse releases exactly one word.
  task automatic test_credit_gate();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = w[i];
      step();
      n_cmp++;
      if ({valid_out, credit_count} !== {1'b0, 3'd0}) begin
        n_bad++;
        $display("FAIL gate_push%0d got %h want %h", i, {valid_out, credit_count}, {1'b0, 3'd0});
      end
    end
    push_valid = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({valid_out, push_ready} !== {1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL gate_idle got %h want %h", {valid_out, push_ready}, {1'b0, 1'b1});
    end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    n_cmp++;
    if ({valid_out, credit_count} !== {1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL gate_credit_edge got %h want %h", {valid_out, credit_count}, {1'b0, 3'd1});
    end
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'h11, 3'd0}) begin
      n_bad++;
      $display("FAIL gate_send got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'h11, 3'd0});
    end
    step();
    n_cmp++;
    if ({valid_out, data_out} !== {1'b0, 8'h11}) begin
      n_bad++;
      $display("FAIL gate_single_only got %h want %h", {valid_out, data_out}, {1'b0, 8'h11});
    end
  endtask

  // Four credits, six words: four back-to-back sends, then two more on credits.
  task automatic test_back_to_back();
    logic [7:0] w  [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed [6] = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h34};
    logic [2:0] ec [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    apply_reset();
    credit_in = 1'b1;
    repeat (3) step();
    credit_in = 1'b0;
    n_cmp++;
    if (credit_count !== 3'd4) begin
      n_bad++;
      $display("FAIL b2b_credits got %0d want 4", credit_count);
    end
    for (int i = 0; i < 6; i++) begin
      push_valid = 1'b1; push_data = w[i];
      step();
      n_cmp++;
      if ({valid_out, data_out, credit_count, push_ready} !== {ev[i], ed[i], ec[i], 1'b1}) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d got %h want %h", i,
                 {valid_out, data_out, credit_count, push_ready}, {ev[i], ed[i], ec[i], 1'b1});
      end
    end
    push_valid = 1'b0;
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b0, 8'h34, 3'd0}) begin
      n_bad++;
      $display("FAIL b2b_stall got %h want %h", {valid_out, data_out, credit_count}, {1'b0, 8'h34, 3'd0});
    end
    credit_in = 1'b1; step(); credit_in = 1'b0;
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'h35, 3'd0}) begin
      n_bad++;
      $display("FAIL b2b_resume5 got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'h35, 3'd0});
    end
    credit_in = 1'b1; step(); credit_in = 1'b0;
    n_cmp++;
    if ({valid_out, credit_count} !== {1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL b2b_credit_edge got %h want %h", {valid_out, credit_count}, {1'b0, 3'd1});
    end
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'h36, 3'd0}) begin
      n_bad++;
      $display("FAIL b2b_resume6 got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'h36, 3'd0});
    end
    step();
    n_cmp++;
    if ({valid_out, push_ready} !== {1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_drained got %h want %h", {valid_out, push_ready}, {1'b0, 1'b1});
    end
  endtask

  // Full FIFO: fifth word waits; a pop while full does not admit a push.
  task automatic test_full();
    logic [7:0] d [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    logic [7:0] drained [4] = '{8'h42, 8'h43, 8'h44, 8'h45};
    logic [2:0] dc [4] = '{3'd1, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = d[i];
      n_cmp++;
      if (push_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL full_ready_pre%0d got %b want 1", i, push_ready);
      end
      step();
    end
    n_cmp++;
    if ({push_ready, valid_out} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL full_ready got %h want %h", {push_ready, valid_out}, {1'b0, 1'b0});
    end
    push_data = d[4];
    repeat (2) step();
    n_cmp++;
    if ({push_ready, valid_out} !== {1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL full_hold got %h want %h", {push_ready, valid_out}, {1'b0, 1'b0});
    end
    credit_in = 1'b1; step(); credit_in = 1'b0;
    n_cmp++;
    if ({push_ready, valid_out, credit_count} !== {1'b0, 1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL full_credit got %h want %h", {push_ready, valid_out, credit_count}, {1'b0, 1'b0, 3'd1});
    end
    step();
    n_cmp++;
    if ({push_ready, valid_out, data_out, credit_count} !== {1'b1, 1'b1, 8'h41, 3'd0}) begin
      n_bad++;
      $display("FAIL full_pop got %h want %h",
               {push_ready, valid_out, data_out, credit_count}, {1'b1, 1'b1, 8'h41, 3'd0});
    end
    step();
    push_valid = 1'b0;
    n_cmp++;
    if ({push_ready, valid_out, credit_count} !== {1'b0, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL full_refill got %h want %h", {push_ready, valid_out, credit_count}, {1'b0, 1'b0, 3'd0});
    end
    credit_in = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) credit_in = 1'b0;
      step();
      n_cmp++;
      if ({valid_out, data_out, credit_count} !== {1'b1, drained[i], dc[i]}) begin
        n_bad++;
        $display("FAIL full_drain%0d got %h want %h", i,
                 {valid_out, data_out, credit_count}, {1'b1, drained[i], dc[i]});
      end
    end
    step();
    n_cmp++;
    if ({valid_out, push_ready, credit_count} !== {1'b0, 1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL full_empty got %h want %h", {valid_out, push_ready, credit_count}, {1'b0, 1'b1, 3'd0});
    end
  endtask

  // Credit returned while saturated with nothing to send: sticky error.
  task automatic test_err();
    credit_in = 1'b1;
    repeat (4) step();
    n_cmp++;
    if ({credit_count, err_out} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL err_at_max got %h want %h", {credit_count, err_out}, {3'd4, 1'b0});
    end
    step();
    credit_in = 1'b0;
    n_cmp++;
    if ({credit_count, err_out} !== {3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL err_set got %h want %h", {credit_count, err_out}, {3'd4, 1'b1});
    end
    repeat (3) step();
    n_cmp++;
    if ({credit_count, err_out, valid_out} !== {3'd4, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL err_sticky got %h want %h", {credit_count, err_out, valid_out}, {3'd4, 1'b1, 1'b0});
    end
  endtask

  // Asynchronous reset mid-operation with words queued and a pending credit.
  task automatic test_mid_reset();
    logic [7:0] q [3] = '{8'h71, 8'h72, 8'h73};
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({push_ready, valid_out, data_out, credit_count, err_out} !== {1'b1, 1'b0, 8'h00, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset_err got %h want %h",
               {push_ready, valid_out, data_out, credit_count, err_out}, {1'b1, 1'b0, 8'h00, 3'd1, 1'b0});
    end
    #1 rst = 1'b0;
    push_valid = 1'b1; push_data = 8'h61;
    step();
    push_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = q[i];
      step();
    end
    push_valid = 1'b0;
    credit_in = 1'b1;
    repeat (2) step();
    credit_in = 1'b0;
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'h71, 3'd1}) begin
      n_bad++;
      $display("FAIL pre_reset_send got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'h71, 3'd1});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({push_ready, valid_out, data_out, credit_count, err_out} !== {1'b1, 1'b0, 8'h00, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset_mid got %h want %h",
               {push_ready, valid_out, data_out, credit_count, err_out}, {1'b1, 1'b0, 8'h00, 3'd1, 1'b0});
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({valid_out, credit_count, push_ready} !== {1'b0, 3'd1, 1'b1}) begin
        n_bad++;
        $display("FAIL no_stale%0d got %h want %h", i, {valid_out, credit_count, push_ready}, {1'b0, 3'd1, 1'b1});
      end
    end
    push_valid = 1'b1; push_data = 8'h5A;
    step();
    push_valid = 1'b0;
    step();
    n_cmp++;
    if ({valid_out, data_out, credit_count} !== {1'b1, 8'h5A, 3'd0}) begin
      n_bad++;
      $display("FAIL post_reset_send got %h want %h", {valid_out, data_out, credit_count}, {1'b1, 8'h5A, 3'd0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_gate();
    test_back_to_back();
    test_full();
    test_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
